// File: rtl/axi_wr_burst_sched_pkg.sv
// Shared widths, frame geometry defaults and state encoding
// for the video write burst scheduler.
package axi_wr_burst_sched_pkg;

  localparam int DEF_AXI_ADDR_WIDTH = 32;
  localparam int DEF_AXI_DATA_WIDTH = 64;
  localparam int DEF_BURST_LEN      = 128;
  localparam int DEF_FIFO_CNT_WIDTH = 11;
  localparam int DEF_FRAME_BEATS    = 259200;
  localparam int DEF_FRAME_NUM      = 3;

  localparam logic [31:0] DEF_FRAME_BASE =
    32'h0000_0000;
  localparam logic [31:0] DEF_FRAME_STRIDE =
    32'h0080_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } sched_st_t;

  function automatic logic [1:0] ring_inc(
    input logic [1:0] idx,
    input int         n
  );
    int t;
    t = int'(idx) + 1;
    if (t >= n) t = 0;
    return 2'(t);
  endfunction

endpackage

// File: rtl/axi_wr_burst_sched_if.sv
// Send_* burst request handshake between the scheduler
// and the AXI DDR write controller.
interface axi_wr_burst_sched_if
  import axi_wr_burst_sched_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH
);

  logic                      Send_START;
  logic [7:0]                Send_BurstLen;
  logic [AXI_ADDR_WIDTH-1:0] Send_Addr;
  logic                      Send_DONE;

  modport master (
    output Send_START,
    output Send_BurstLen,
    output Send_Addr,
    input  Send_DONE
  );

  modport slave (
    input  Send_START,
    input  Send_BurstLen,
    input  Send_Addr,
    output Send_DONE
  );

endinterface

// File: rtl/axi_wr_burst_sched_frame_ring_idx.sv
// Frame buffer ring index: next write buffer with a skip
// over the buffer currently exposed to the read side.
module frame_ring_idx
  import axi_wr_burst_sched_pkg::*;
#(
  parameter int FRAME_NUM = DEF_FRAME_NUM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic [1:0] rd_idx,
  output logic [1:0] wr_idx,
  output logic [1:0] nxt_idx
);

  logic       primed;
  logic [1:0] inc1;
  logic [1:0] inc2;

  // The first SOF after reset claims buffer 0 itself.
  always_comb begin
    inc1 = ring_inc(wr_idx, FRAME_NUM);
    inc2 = ring_inc(inc1, FRAME_NUM);
    nxt_idx = wr_idx;
    if (primed)
      nxt_idx = (inc1 == rd_idx) ? inc2 : inc1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= 2'd0;
      primed <= 1'b0;
    end else if (adv) begin
      wr_idx <= nxt_idx;
      primed <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_wr_burst_sched.sv
// Write burst scheduler: FIFO-level driven burst issue,
// frame ring addressing and SOF/frame-boundary tracking.
module axi_wr_burst_sched
  import axi_wr_burst_sched_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = DEF_AXI_ADDR_WIDTH,
  parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int FIFO_CNT_WIDTH = DEF_FIFO_CNT_WIDTH,
  parameter int FRAME_BEATS    = DEF_FRAME_BEATS,
  parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE =
    AXI_ADDR_WIDTH'(DEF_FRAME_BASE),
  parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE =
    AXI_ADDR_WIDTH'(DEF_FRAME_STRIDE),
  parameter int FRAME_NUM      = DEF_FRAME_NUM
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESET,
  input  logic                      Cfg_enable,
  input  logic                      Frame_sof,
  input  logic [FIFO_CNT_WIDTH-1:0] Fifo_rd_count,
  axi_wr_burst_sched_if.master      send,
  output logic                      Fifo_flush,
  output logic [1:0]                Wr_frame_idx,
  output logic [1:0]                Rd_frame_idx,
  output logic                      Frame_done,
  output logic                      Frame_err
);

  localparam int BW = $clog2(FRAME_BEATS + 1);
  localparam int SH = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [BW-1:0] FB = BW'(FRAME_BEATS);

  sched_st_t                 st;
  logic [BW-1:0]             beat_cnt;
  logic                      sof_pend;
  logic                      start_q;
  logic [7:0]                len_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;

  logic [BW-1:0]             rem;
  logic [7:0]                need;
  logic [BW:0]               beat_sum;
  logic                      sof_now;
  logic                      go;
  logic                      part_frame;
  logic [1:0]                nxt_idx;

  always_comb begin
    rem = FB - beat_cnt;
    need = 8'(BURST_LEN);
    if (32'(rem) < 32'(BURST_LEN))
      need = 8'(rem);
    beat_sum = {1'b0, beat_cnt}
             + (BW + 1)'(len_q);
    part_frame = (beat_cnt != '0)
              && (beat_cnt < FB);
    // A pending SOF always wins over a new burst.
    sof_now = (st == ST_IDLE)
           && (sof_pend || Frame_sof);
    go = (st == ST_IDLE) && !sof_now
      && Cfg_enable && (beat_cnt < FB)
      && (32'(Fifo_rd_count) >= 32'(need));
  end

  frame_ring_idx #(
    .FRAME_NUM (FRAME_NUM)
  ) u_ring (
    .clk     (M_AXI_ACLK),
    .rst     (M_AXI_ARESET),
    .adv     (sof_now),
    .rd_idx  (Rd_frame_idx),
    .wr_idx  (Wr_frame_idx),
    .nxt_idx (nxt_idx)
  );

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      st           <= ST_IDLE;
      beat_cnt     <= FB;
      sof_pend     <= 1'b0;
      start_q      <= 1'b0;
      len_q        <= 8'd0;
      addr_q       <= FRAME_BASE;
      Fifo_flush   <= 1'b0;
      Rd_frame_idx <= 2'(FRAME_NUM - 1);
      Frame_done   <= 1'b0;
      Frame_err    <= 1'b0;
    end else begin
      Fifo_flush <= 1'b0;
      Frame_done <= 1'b0;
      Frame_err  <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (sof_now) begin
            sof_pend <= 1'b0;
            beat_cnt <= '0;
            addr_q   <= FRAME_BASE
                      + AXI_ADDR_WIDTH'(nxt_idx)
                      * FRAME_STRIDE;
            if (part_frame) begin
              Frame_err  <= 1'b1;
              Fifo_flush <= 1'b1;
            end
          end else if (go) begin
            start_q <= 1'b1;
            len_q   <= need;
            st      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sof_pend <= sof_pend | Frame_sof;
          if (send.Send_DONE) begin
            start_q  <= 1'b0;
            beat_cnt <= beat_sum[BW-1:0];
            addr_q   <= addr_q
                      + (AXI_ADDR_WIDTH'(len_q) << SH);
            if (beat_sum == {1'b0, FB}) begin
              Frame_done   <= 1'b1;
              Rd_frame_idx <= Wr_frame_idx;
            end
            st <= ST_GAP;
          end
        end
        ST_GAP: begin
          // One low cycle re-arms the controller's edge detect.
          sof_pend <= sof_pend | Frame_sof;
          st       <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign send.Send_START    = start_q;
  assign send.Send_BurstLen = len_q;
  assign send.Send_Addr     = addr_q;

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Scoreboard bench for axi_wr_burst_sched with a short
// 300-beat frame and a non-zero ring base.
module tb_axi_wr_burst_sched;
  import axi_wr_burst_sched_pkg::*;

  localparam int FB = 300;
  localparam int BL = 128;
  localparam logic [31:0] B = 32'h0100_0000;
  localparam logic [31:0] S = 32'h0080_0000;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b0;
  logic        sof = 1'b0;
  logic [10:0] fifo_cnt = '0;
  logic        flush;
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;
  logic        fdone;
  logic        ferr;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int flush_cnt = 0;
  exp_t sbq[$];

  axi_wr_burst_sched_if #(.AXI_ADDR_WIDTH(32)) bus ();

  axi_wr_burst_sched #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (64),
    .BURST_LEN      (BL),
    .FIFO_CNT_WIDTH (11),
    .FRAME_BEATS    (FB),
    .FRAME_BASE     (B),
    .FRAME_STRIDE   (S),
    .FRAME_NUM      (3)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (rst),
    .Cfg_enable    (cfg_en),
    .Frame_sof     (sof),
    .Fifo_rd_count (fifo_cnt),
    .send          (bus),
    .Fifo_flush    (flush),
    .Wr_frame_idx  (wr_idx),
    .Rd_frame_idx  (rd_idx),
    .Frame_done    (fdone),
    .Frame_err     (ferr)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      done_cnt  += int'(fdone);
      err_cnt   += int'(ferr);
      flush_cnt += int'(flush);
      if (ferr || flush)
        chk("err_flush_pair", 64'(flush), 64'(ferr));
    end
  end

  task automatic expect_burst(
    input logic [31:0] a,
    input int          l
  );
    exp_t e;
    e.addr = a;
    e.len  = 8'(l);
    sbq.push_back(e);
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
  endtask

  task automatic take_burst(output bit ok);
    exp_t e;
    int   n;
    ok = 1'b0;
    n  = 0;
    while (!bus.Send_START && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Send_START) begin
      chk("start_timeout", 64'(0), 64'(1));
      return;
    end
    if (sbq.size() == 0) begin
      chk("sb_underflow", 64'(1), 64'(0));
      return;
    end
    e = sbq.pop_front();
    chk("burst_addr", 64'(bus.Send_Addr),
        64'(e.addr));
    chk("burst_len", 64'(bus.Send_BurstLen),
        64'(e.len));
    ok = 1'b1;
  endtask

  task automatic serve(
    input int lat,
    input bit sof_on_done,
    input int fifo_at_done
  );
    bit          ok;
    logic [31:0] a;
    take_burst(ok);
    if (!ok) return;
    a = bus.Send_Addr;
    repeat (lat) begin
      @(negedge clk);
      chk("hold_start", 64'(bus.Send_START), 64'(1));
      chk("hold_addr", 64'(bus.Send_Addr), 64'(a));
    end
    bus.Send_DONE = 1'b1;
    sof = sof_on_done;
    if (fifo_at_done >= 0)
      fifo_cnt = 11'(fifo_at_done);
    @(negedge clk);
    bus.Send_DONE = 1'b0;
    sof = 1'b0;
    chk("gap_start", 64'(bus.Send_START), 64'(0));
    @(negedge clk);
    chk("idle_start", 64'(bus.Send_START), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.Send_DONE = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 64'(bus.Send_START), 64'(0));
    chk("rst_len", 64'(bus.Send_BurstLen), 64'(0));
    chk("rst_addr", 64'(bus.Send_Addr), 64'(B));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_wr", 64'(wr_idx), 64'(0));
    chk("rst_rd", 64'(rd_idx), 64'(2));
    chk("rst_done", 64'(fdone), 64'(0));
    chk("rst_err", 64'(ferr), 64'(0));

    rst = 1'b0;
    cfg_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("nosof_stall", 64'(bus.Send_START), 64'(0));

    // first SOF: buffer 0, no error
    pulse_sof();
    repeat (3) @(negedge clk);
    chk("sof1_wr", 64'(wr_idx), 64'(0));
    chk("sof1_addr", 64'(bus.Send_Addr), 64'(B));
    chk("sof1_err", 64'(err_cnt), 64'(0));
    chk("fifo0_idle", 64'(bus.Send_START), 64'(0));

    // FIFO rises to 200: one 128-beat burst
    fifo_cnt = 11'd200;
    expect_burst(B, 128);
    serve(3, 1'b0, -1);
    chk("addr_adv", 64'(bus.Send_Addr),
        64'(B + 32'd1024));
    expect_burst(B + 32'd1024, 128);
    @(negedge clk);
    chk("b2b_start", 64'(bus.Send_START), 64'(1));
    serve(2, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("low_fifo", 64'(bus.Send_START), 64'(0));

    // SOF after 256 of 300 beats
    pulse_sof();
    @(negedge clk);
    chk("part_err", 64'(err_cnt), 64'(1));
    chk("part_flush", 64'(flush_cnt), 64'(1));
    chk("part_wr", 64'(wr_idx), 64'(1));
    chk("part_addr", 64'(bus.Send_Addr), 64'(B + S));
    chk("part_nodone", 64'(done_cnt), 64'(0));

    // full frame in buffer 1: 128, 128, 44
    fifo_cnt = 11'd2047;
    expect_burst(B + S, 128);
    expect_burst(B + S + 32'd1024, 128);
    expect_burst(B + S + 32'd2048, 44);
    serve(1, 1'b0, -1);
    @(negedge clk);
    chk("b2b_1", 64'(bus.Send_START), 64'(1));
    serve(4, 1'b0, -1);
    @(negedge clk);
    chk("b2b_2", 64'(bus.Send_START), 64'(1));
    serve(2, 1'b0, -1);
    chk("fdone_cnt", 64'(done_cnt), 64'(1));
    chk("fdone_rd", 64'(rd_idx), 64'(1));
    chk("fdone_addr", 64'(bus.Send_Addr),
        64'(B + S + 32'd2400));
    repeat (5) begin
      @(negedge clk);
      chk("eof_stall", 64'(bus.Send_START), 64'(0));
    end
    chk("eof_noerr", 64'(err_cnt), 64'(1));

    // SOF into buffer 2, then SOF on the DONE cycle
    expect_burst(B + 2 * S, 128);
    pulse_sof();
    serve(1, 1'b1, -1);
    chk("sofdone_defer", 64'(err_cnt), 64'(1));
    chk("sofdone_wr", 64'(wr_idx), 64'(2));
    expect_burst(B, 128);
    serve(1, 1'b0, 0);
    chk("sofdone_err", 64'(err_cnt), 64'(2));
    chk("sofdone_flush", 64'(flush_cnt), 64'(2));
    chk("sofdone_wr0", 64'(wr_idx), 64'(0));
    chk("sofdone_done", 64'(done_cnt), 64'(1));

    // writing 0, reading 1: next SOF skips to 2
    pulse_sof();
    @(negedge clk);
    chk("skip_wr", 64'(wr_idx), 64'(2));
    chk("skip_rd", 64'(rd_idx), 64'(1));
    chk("skip_addr", 64'(bus.Send_Addr),
        64'(B + 2 * S));
    chk("skip_err", 64'(err_cnt), 64'(3));

    // reset while Send_START is high
    fifo_cnt = 11'd2047;
    expect_burst(B + 2 * S, 128);
    take_burst(ok);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_start", 64'(bus.Send_START), 64'(0));
    chk("arst_len", 64'(bus.Send_BurstLen), 64'(0));
    chk("arst_addr", 64'(bus.Send_Addr), 64'(B));
    chk("arst_wr", 64'(wr_idx), 64'(0));
    chk("arst_rd", 64'(rd_idx), 64'(2));
    chk("arst_flush", 64'(flush), 64'(0));
    chk("arst_done", 64'(fdone), 64'(0));
    chk("arst_err", 64'(ferr), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_stall", 64'(bus.Send_START), 64'(0));
    chk("sb_left", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
